// File: rtl/button_events.sv
// Button gesture decoder: turns a debounced button level into press, release,
// click, long-press and auto-repeat pulses, plus a held level.
module button_events #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clean_in,
    output logic       press,
    // "release" and "repeat" are reserved words, hence the _pulse suffix
    output logic       release_pulse,
    output logic       click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] dbg_state
);

    localparam longint LONG_RAW   = (longint'(LONG_PRESS_MS) * 64'sd1000000) / longint'(CLK_PERIOD_NS);
    localparam longint REPEAT_RAW = (longint'(REPEAT_MS) * 64'sd1000000) / longint'(CLK_PERIOD_NS);
    localparam int LONG_CYCLES    = (LONG_RAW < 1) ? 1 : int'(LONG_RAW);
    localparam int REPEAT_CYCLES  = (REPEAT_RAW < 1) ? 1 : int'(REPEAT_RAW);
    localparam int MAX_CYCLES     = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W          = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_in_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a sampled 0->1 edge starts a press; a level held through reset does not.
                if (clean_in && !last_in_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!clean_in) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LONG: begin
                if (!clean_in) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    end

    // last_in keeps tracking the input even during reset.
    always_ff @(posedge clk) begin
        last_in_q <= clean_in;
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign click         = click_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_events.sv
// Scenario bench for button_events with LONG_CYCLES=5 and REPEAT_CYCLES=2.
// Output vector order: {press, release, click, long_press, repeat, held}.
module tb_button_events;

  logic       clk = 1'b0;
  logic       rst;
  logic       clean_in;
  logic       press;
  logic       release_pulse;
  logic       click;
  logic       long_press;
  logic       repeat_pulse;
  logic       held;
  logic [1:0] dbg_state;
  logic [5:0] obs;

  logic [5:0] exp_q[$];
  logic [1:0] stim_q[$];   // {rst, clean_in} per clock edge
  int         checks   = 0;
  int         failures = 0;

  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_PRESS = 6'b100001;
  localparam logic [5:0] E_HELD  = 6'b000001;
  localparam logic [5:0] E_LONG  = 6'b000101;
  localparam logic [5:0] E_REP   = 6'b000011;
  localparam logic [5:0] E_CLICK = 6'b011000;
  localparam logic [5:0] E_REL   = 6'b010000;

  button_events #(
    .CLK_PERIOD_NS(1_000_000),
    .LONG_PRESS_MS(5),
    .REPEAT_MS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clean_in(clean_in),
    .press(press),
    .release_pulse(release_pulse),
    .click(click),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse),
    .held(held),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  assign obs = {press, release_pulse, click, long_press, repeat_pulse, held};

  // driver: apply inputs mid-cycle, then sample outputs 1 time unit after the edge
  task automatic drive_edge(input logic r, input logic c);
    rst      = r;
    clean_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic r, input logic c, input logic [5:0] e);
    stim_q.push_back({r, c});
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [1:0] s;
    logic [5:0] e;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, E_NONE);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, E_NONE);  // level held over reset: no press
    push(1'b0, 1'b0, E_NONE);
    push(1'b0, 1'b1, E_PRESS);
    push(1'b0, 1'b0, E_CLICK);
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL reset cycle %0d: got output %b required an expectation (queue empty)", k, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          failures++;
          $display("FAIL reset cycle %0d: got %b required %b", k, obs, e);
        end
      end
    end
  endtask

  task automatic test_short_press();
    logic [1:0] s;
    logic [5:0] e;
    push(1'b0, 1'b1, E_PRESS);
    push(1'b0, 1'b1, E_HELD);
    push(1'b0, 1'b1, E_HELD);
    push(1'b0, 1'b0, E_CLICK);
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL short_press P+%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [1:0] s;
    logic [5:0] e;
    for (int k = 0; k < 14; k++) begin
      if (k == 0)                                   e = E_PRESS;
      else if (k == 5)                              e = E_LONG;
      else if (k == 7 || k == 9 || k == 11 || k == 13) e = E_REP;
      else                                          e = E_HELD;
      push(1'b0, 1'b1, e);
    end
    push(1'b0, 1'b0, E_REL);  // release without click after long_press
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL long_hold P+%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_coincident_fall();
    logic [1:0] s;
    logic [5:0] e;
    push(1'b0, 1'b1, E_PRESS);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, E_HELD);
    push(1'b0, 1'b0, E_CLICK);  // falls on the terminal-count edge
    push(1'b0, 1'b0, E_NONE);
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL coincident_fall P+%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] s;
    logic [5:0] e;
    push(1'b0, 1'b1, E_PRESS);
    push(1'b0, 1'b0, E_CLICK);
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL glitch P+%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_in_long();
    logic [1:0] s;
    logic [5:0] e;
    push(1'b0, 1'b1, E_PRESS);
    for (int i = 1; i < 5; i++) push(1'b0, 1'b1, E_HELD);
    push(1'b0, 1'b1, E_LONG);
    push(1'b0, 1'b1, E_HELD);
    push(1'b1, 1'b1, E_NONE);  // reset replaces the due repeat, no release
    push(1'b1, 1'b1, E_NONE);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, E_NONE);
    push(1'b0, 1'b0, E_NONE);
    push(1'b0, 1'b1, E_PRESS);
    push(1'b0, 1'b0, E_CLICK);
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_in_long step %0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] s;
    logic [5:0] e;
    push(1'b0, 1'b1, E_PRESS);
    push(1'b0, 1'b0, E_CLICK);
    push(1'b0, 1'b1, E_PRESS);
    push(1'b0, 1'b0, E_CLICK);
    push(1'b0, 1'b0, E_NONE);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back P+%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  // random short taps (hold below LONG_CYCLES) with random gaps
  task automatic test_random_taps();
    logic [1:0] s;
    logic [5:0] e;
    int hi;
    int lo;
    for (int b = 0; b < 8; b++) begin
      hi = $urandom_range(1, 4);
      lo = $urandom_range(1, 3);
      for (int i = 0; i < hi; i++) push(1'b0, 1'b1, (i == 0) ? E_PRESS : E_HELD);
      for (int i = 0; i < lo; i++) push(1'b0, 1'b0, (i == 0) ? E_CLICK : E_NONE);
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      drive_edge(s[1], s[0]);
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL random_taps step %0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    clean_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_short_press();
    test_long_hold();
    test_coincident_fall();
    test_glitch();
    test_reset_in_long();
    test_back_to_back();
    test_random_taps();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
